// File: rtl/counter_seq_ctrl_if.sv
// Command/status bundle between the tile command pins, counter_seq_ctrl and the
// 8-bit counter datapath. The slave modport is the sequencer's view.
interface counter_seq_ctrl_if #(
    parameter int PRE_W = 8,
    parameter int CNT_W = 8
);
    logic             cmd_start;
    logic             cmd_stop;
    logic             cmd_clear;
    logic             oneshot;
    logic [PRE_W-1:0] prescale;
    logic [CNT_W-1:0] tc_value;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_inc;
    logic             cnt_clr;
    logic [1:0]       state;
    logic             busy;
    logic             done_pulse;
    logic             wrap_pulse;

    modport master (
        output cmd_start, cmd_stop, cmd_clear, oneshot, prescale, tc_value, cnt_val,
        input  cnt_inc, cnt_clr, state, busy, done_pulse, wrap_pulse
    );

    modport slave (
        input  cmd_start, cmd_stop, cmd_clear, oneshot, prescale, tc_value, cnt_val,
        output cnt_inc, cnt_clr, state, busy, done_pulse, wrap_pulse
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Run/pause/clear sequencer with prescaler and terminal-count handling for the counter datapath.
// Optional command debounce is enabled by defining CNT_SEQ_DEBOUNCE_EN.
module counter_seq_ctrl #(
    parameter int PRE_W      = 8,
    parameter int CNT_W      = 8,
    parameter int DEB_CYCLES = 4
) (
    input logic               clk,
    input logic               rst_n,
    counter_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
        $error("counter_seq_ctrl: DEB_CYCLES must be at least 1");
    end

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             inc, clr;
    logic [CNT_W-1:0] cnt_val, tc_value;
    logic [2:0]       cmd_raw, cmd_lvl, cmd_hist, evt;
    logic             tick;

    assign cmd_raw  = {bus.cmd_clear, bus.cmd_stop, bus.cmd_start};
    assign cnt_val  = bus.cnt_val;
    assign tc_value = bus.tc_value;

`ifdef CNT_SEQ_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [2:0]       sync1, sync2;
    logic [DEB_W-1:0] deb_cnt [3];

    // The filtered level moves only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            cmd_lvl <= '0;
            // NOTE: the small debounce counter array is reset explicitly; it is
            // control state, not a data memory, so it must never start unknown.
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= cmd_raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == cmd_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    cmd_lvl[i] <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign cmd_lvl = cmd_raw;
`endif

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            cmd_hist <= '0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
            cmd_hist <= cmd_lvl;
        end
    end

    assign evt  = cmd_lvl & ~cmd_hist;
    // A clear or stop in the same cycle suppresses the tick; >= tolerates a live prescale drop.
    assign tick = (state_q == RUN) && (pre_q >= bus.prescale) && !evt[2] && !evt[1];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        state_d = state_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        inc     = 1'b0;
        clr     = 1'b0;
        if (!rst_n) begin
            inc = 1'b0;
        end else if (evt[2]) begin
            clr     = 1'b1;
            state_d = IDLE;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: if (evt[0]) begin
                    state_d = RUN;
                    pre_d   = '0;
                end
                PAUSE: if (evt[0]) state_d = RUN;
                DONE: if (evt[0]) begin
                    clr     = 1'b1;
                    state_d = RUN;
                    pre_d   = '0;
                end
                RUN: begin
                    if (evt[1]) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        pre_d = '0;
                        if (cnt_val != tc_value) begin
                            inc = 1'b1;
                        end else if (bus.oneshot) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            clr    = 1'b1;
                            wrap_d = 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.cnt_inc    = inc;
    assign bus.cnt_clr    = clr;
    assign bus.state      = state_q;
    assign bus.busy       = (state_q == RUN);
    assign bus.done_pulse = done_q;
    assign bus.wrap_pulse = wrap_q;

endmodule
